// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing constants for the mm:ss stopwatch controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_t;

   localparam int unsigned DEF_TICK_DIV   = 5000000;
   localparam int unsigned DEF_TICK_W     = 23;
   localparam int unsigned DEF_DEB_CYCLES = 50000;
   localparam int unsigned DEF_DEB_W      = 16;

endpackage

// File: rtl/button_conditioner.sv
// Raw button -> 2-flop sync -> debounce (STOPWATCH_DEBOUNCE_EN) -> one-cycle press pulse.
module button_conditioner #(
   parameter int unsigned DEB_CYCLES = 50000,
   parameter int unsigned DEB_W      = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   logic sync1;
   logic sync2;
   logic level;
   logic level_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

`ifdef STOPWATCH_DEBOUNCE_EN
   logic [DEB_W-1:0] deb_cnt;

   // Accept a new level only after DEB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level   <= 1'b0;
         deb_cnt <= '0;
      end else if (sync2 != level) begin
         if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            level   <= sync2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end else begin
         deb_cnt <= '0;
      end
   end
`else
   // Debounce sizing is ignored in this build; both arms pass the synchronized level through.
   if ((DEB_CYCLES + DEB_W) != 0) begin : g_direct
      assign level = sync2;
   end else begin : g_direct_zero
      assign level = sync2;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_d <= level;
         press   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear sequencer and 1 Hz prescaler for the mm:ss stopwatch.
// Build option: STOPWATCH_DEBOUNCE_EN enables the button debounce filter.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned TICK_W     = DEF_TICK_W,
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned DEB_W      = DEF_DEB_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lr,
   input  logic       at_max,
   output logic       cnt_ce,
   output logic       cnt_clr,
   output logic       freeze,
   output logic       running,
   output logic [1:0] state
);

   logic              ss_p;
   logic              lr_p;
   state_t            state_q;
   state_t            state_d;
   logic [TICK_W-1:0] presc_q;
   logic [TICK_W-1:0] presc_d;
   logic              ce_d;
   logic              clr_d;
   logic              tick;

   button_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_cond_ss (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_ss),
      .press (ss_p)
   );

   button_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_cond_lr (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_lr),
      .press (lr_p)
   );

   assign tick = (presc_q == TICK_W'(TICK_DIV - 1));

   // Next state, prescaler and output strobes; ss_p always takes priority over lr_p.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      ce_d    = 1'b0;
      clr_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            presc_d = '0;
            if (ss_p) begin
               state_d = ST_RUN;
            end else if (lr_p) begin
               clr_d = 1'b1;
            end
         end
         ST_RUN, ST_LAP: begin
            presc_d = tick ? '0 : presc_q + TICK_W'(1);
            if (tick && at_max) begin
               // Saturate at 59:59: stop without counting and drop the partial second.
               state_d = ST_PAUSE;
               presc_d = '0;
            end else begin
               ce_d = tick;
               if (ss_p) begin
                  state_d = ST_PAUSE;
               end else if (lr_p) begin
                  state_d = (state_q == ST_RUN) ? ST_LAP : ST_RUN;
               end
            end
         end
         ST_PAUSE: begin
            if (ss_p) begin
               state_d = ST_RUN;
            end else if (lr_p) begin
               state_d = ST_IDLE;
               clr_d   = 1'b1;
               presc_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            presc_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         cnt_ce  <= 1'b0;
         cnt_clr <= 1'b0;
         freeze  <= 1'b0;
         running <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_ce  <= ce_d;
         cnt_clr <= clr_d;
         freeze  <= (state_d == ST_LAP);
         running <= (state_d == ST_RUN) || (state_d == ST_LAP);
      end
   end

   assign state = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the mm:ss stopwatch datapath. It conditions the two front-panel buttons and runs the start/stop/lap/clear state machine. It also owns the 1 Hz prescaler, so the seconds/minutes binary counters need only a clock enable and a synchronous clear. It sits between the board buttons and the counter/BCD/7-segment chain, and drives the display freeze used for lap hold.

## Interface
Parameters:
- TICK_DIV, 5000000, clk cycles per counted second (1 Hz at 5 MHz clk)
- TICK_W, 23, prescaler width; must hold TICK_DIV-1
- DEB_CYCLES, 50000, cycles a synchronized button level must be stable to be accepted (10 ms)
- DEB_W, 16, debounce counter width

Ports:
- clk  in  1  system clock (clock-wizard output domain)
- reset  in  1  asynchronous, active-low reset
- btn_ss  in  1  raw start/stop button, active-high, asynchronous
- btn_lr  in  1  raw lap/reset button, active-high, asynchronous
- at_max  in  1  from counters: count is 59:59
- cnt_ce  out  1  one-cycle clock enable to seconds counter
- cnt_clr  out  1  one-cycle synchronous clear to seconds and minutes counters
- freeze  out  1  display latch hold (lap)
- running  out  1  high in RUN or LAP (drives decimal point LED)
- state  out  2  current state encoding

## Operation
- Each button passes through a 2-flop synchronizer, a debounce filter, and a rising-edge detector, producing a one-cycle press pulse (ss_p, lr_p).
- States: IDLE=00, RUN=01, PAUSE=10, LAP=11.
- IDLE: prescaler held at 0. ss_p goes to RUN. lr_p stays in IDLE and pulses cnt_clr.
- RUN: prescaler counts 0..TICK_DIV-1 and wraps. ss_p goes to PAUSE. lr_p goes to LAP.
- PAUSE: prescaler holds its value, so no partial second is lost. ss_p goes to RUN. lr_p goes to IDLE, pulses cnt_clr, and zeroes the prescaler.
- LAP: counting continues and freeze=1. lr_p goes to RUN (freeze released). ss_p goes to PAUSE (freeze released).
- ss_p and lr_p in the same cycle: ss_p wins and lr_p is discarded.
- Tick: cnt_ce fires in RUN/LAP when the prescaler equals TICK_DIV-1 and at_max=0.
- Tick with at_max=1: no cnt_ce is issued, the FSM goes to PAUSE, freeze clears, and the prescaler clears (saturate at 59:59).
- A state change and a tick in the same cycle: the tick is evaluated against the current state, so a tick in RUN still fires even if ss_p arrives that cycle.

## Timing
- All outputs are registered. Reset values: cnt_ce=0, cnt_clr=0, freeze=0, running=0, state=00. The prescaler and debounce counters reset to 0, and the debounced levels reset to 0 (released).
- Reset deassertion mid-run always returns to IDLE. Counters are not cleared by this block on reset; the top level ORs the system reset into the counters' SCLR.
- Button latency with debounce: a raw level must be stable for 2 sync cycles plus DEB_CYCLES before it is accepted. The press pulse appears on the next edge, and state/outputs update one edge after that. Any bounce restarts the debounce count.
- cnt_ce is high for exactly one cycle per TICK_DIV cycles while counting. Its first pulse after IDLE→RUN comes TICK_DIV cycles after entry.
- cnt_clr is high for exactly one cycle, asserted on the edge that takes the FSM into or through IDLE via lr_p.
- freeze rises on the edge entering LAP and falls on the edge leaving it.

## Configuration
- STOPWATCH_DEBOUNCE_EN defined: the full debounce filter is included, with DEB_CYCLES stability required.
- STOPWATCH_DEBOUNCE_EN undefined: the debounce counter is removed. The edge detector takes the synchronizer output directly, so press latency is 3 edges. DEB_CYCLES and DEB_W are ignored. This mode is for simulation speed only.

## Structure
- Shared package stopwatch_pkg holds:
  - state localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP
  - default TICK_DIV and DEB_CYCLES constants
- One sub-module, button_conditioner, handles sync, debounce (macro-gated), and rising-edge pulse. It is instantiated twice.
- The FSM and prescaler live in stopwatch_ctrl.

## Test plan
Bench parameters: TICK_DIV=10, DEB_CYCLES=4, macro defined.
- Reset low then released, no presses → state=00, all outputs 0, no cnt_ce for 100 cycles.
- btn_ss held 10 cycles → RUN, running=1. cnt_ce pulses every 10 cycles, first pulse 10 cycles after entry. A 2-cycle glitch on btn_ss produces no state change.
- RUN, press ss at prescaler=6, wait 30 cycles, press ss → no cnt_ce while paused. The next cnt_ce comes 3 cycles after resuming.
- RUN, press lr → freeze=1, cnt_ce continues. Press lr → freeze=0, state=RUN.
- PAUSE, press lr → one-cycle cnt_clr, state=00, prescaler 0. Both buttons pressed in the same cycle from PAUSE → RUN, no cnt_clr.
- RUN with at_max=1 at prescaler=9 → no cnt_ce, state=PAUSE. Reset asserted mid-LAP → freeze=0 immediately.
